// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction prefetch front-end.
package instr_fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned WORD_BYTES  = INSTR_WIDTH / 8;
  localparam int unsigned OFFS_BITS   = $clog2(WORD_BYTES);

  // Fetch control state; kept as plain constants for legacy tool flows.
  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t IDLE  = 1'b0;
  localparam fetch_state_t FETCH = 1'b1;

  // FIFO payload for the default 8-bit address configuration.
  typedef struct packed {
    logic [7:0]             pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush; push and pop may occur in the same cycle.
module instr_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fifo_entry_t,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  entry_t       wdata,
  input  logic         pop,
  input  logic         flush,
  output entry_t       head,
  output logic [PTR_W:0] level,
  output logic         full,
  output logic         empty
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop) & ~flush;

  // Pointer and occupancy bookkeeping; flush drops everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Payload storage; needs no reset since empty entries are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = cnt_q;

endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: sequential RAM reads into a FIFO, branch flush/squash.
module instr_prefetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  localparam int unsigned          LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [LVL_W-1:0]      level_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, tag_q, tgt, mem_addr;
  logic                  inflight_q, issue_ok, room, mem_en;
  logic [LVL_W-1:0]      level, occupancy;
  logic                  full, empty, push, pop;
  entry_t                head, wdata;

  assign tgt = {branch_addr_i[ADDR_WIDTH-1:OFFS_BITS], {OFFS_BITS{1'b0}}};

  // Fetch FSM; entering FETCH issues in the same cycle so the first read is not delayed.
  always_comb begin
    state_d  = state_q;
    issue_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en_i) begin
          state_d  = FETCH;
          issue_ok = 1'b1;
        end
      end
      FETCH: begin
        if (fetch_en_i) issue_ok = 1'b1;
        else            state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reserve a slot for the read in flight so its data always has room.
  assign occupancy = level + LVL_W'(inflight_q);
  assign room      = (occupancy < LVL_W'(DEPTH));

  // Issue decision and next fetch pc; a branch overrides everything and ignores occupancy.
  always_comb begin
    mem_en     = 1'b0;
    mem_addr   = fetch_pc_q;
    fetch_pc_d = fetch_pc_q;
    if (branch_i) begin
      mem_addr   = tgt;
      fetch_pc_d = tgt;
      if (issue_ok) begin
        mem_en     = 1'b1;
        fetch_pc_d = tgt + ADDR_WIDTH'(WORD_BYTES);
      end
    end else if (issue_ok && room) begin
      mem_en     = 1'b1;
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(WORD_BYTES);
    end
  end

  // Control state and the pc tag of the outstanding read.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT_ADDR;
      inflight_q <= 1'b0;
      tag_q      <= BOOT_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= mem_en;
      if (mem_en) tag_q <= mem_addr;
    end
  end

  // A branch squashes the returning read by simply not pushing it.
  assign push  = inflight_q & ~branch_i;
  assign pop   = ~empty & ready_i & ~branch_i;
  assign wdata = '{pc: tag_q, instr: mem_rdata_i};

  instr_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_i),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (branch_i),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Reset must silence the RAM even though the enable is combinational.
  assign mem_en_o   = mem_en & ~rst_i;
  assign mem_addr_o = mem_addr;
  assign valid_o    = ~empty;
  assign instr_o    = empty ? '0 : head.instr;
  assign pc_o       = empty ? fetch_pc_q : head.pc;
  assign level_o    = level;

  logic unused_full;
  assign unused_full = full;

endmodule
